// File: rtl/nes_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nes_clock_sequencer
// Brief    : Synchronises the PLL lock flag, holds the NES core in reset until
//            lock has been stable for LOCK_HOLD cycles, then generates the
//            phase-aligned CPU and PPU clock-enable strobes.
// Options  : NES_CLOCK_SEQ_PAUSE_EN adds a synchronous `pause` input that
//            freezes both clock-enable dividers while running.
// Revision : 1.0 - initial release
// ============================================================================
module nes_clock_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_HOLD   = 1024,
   parameter int CPU_DIV     = 12,
   parameter int PPU_DIV     = 4
) (
   input  logic       refclk,
   input  logic       rst,
`ifdef NES_CLOCK_SEQ_PAUSE_EN
   input  logic       pause,
`endif
   input  logic       pll_locked,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       cpu_ce,
   output logic       ppu_ce,
   output logic [7:0] lock_lost_cnt
);

   localparam int HOLD_W = $clog2(LOCK_HOLD);
   localparam int CPU_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
   localparam int PPU_W  = (PPU_DIV > 1) ? $clog2(PPU_DIV) : 1;

   localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LOCK_HOLD - 1);
   localparam logic [HOLD_W-1:0] c_hold_one  = HOLD_W'(1);
   localparam logic [CPU_W-1:0]  c_cpu_last  = CPU_W'(CPU_DIV - 1);
   localparam logic [CPU_W-1:0]  c_cpu_one   = CPU_W'(1);
   localparam logic [PPU_W-1:0]  c_ppu_last  = PPU_W'(PPU_DIV - 1);
   localparam logic [PPU_W-1:0]  c_ppu_one   = PPU_W'(1);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_HOLD      = 2'd1,
      ST_RUN       = 2'd2,
      ST_LOST      = 2'd3
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;
   logic [HOLD_W-1:0]      r_hold_cnt;
   logic [HOLD_W-1:0]      w_hold_next;
   logic [CPU_W-1:0]       r_cpu_div;
   logic [CPU_W-1:0]       w_cpu_div_next;
   logic [PPU_W-1:0]       r_ppu_div;
   logic [PPU_W-1:0]       w_ppu_div_next;
   logic                   r_run;
   logic [7:0]             r_lost_cnt;
   logic                   w_pause;
   logic                   w_run_active;
   logic                   w_stay_run;

`ifdef NES_CLOCK_SEQ_PAUSE_EN
   assign w_pause = pause;
`else
   assign w_pause = 1'b0;
`endif

   // pll_locked is asynchronous; only the last synchroniser stage is used.
   assign w_locked_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_WAIT_LOCK;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_hold_cnt <= w_hold_next;
      end
   end

   // Hold counter is only non-zero while in HOLD; it clears on any exit.
   always_comb begin
      w_state_next = r_state;
      w_hold_next  = '0;
      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (!w_locked_s) begin
               w_state_next = ST_WAIT_LOCK;
            end else if (r_hold_cnt == c_hold_last) begin
               w_state_next = ST_RUN;
            end else begin
               w_hold_next = r_hold_cnt + c_hold_one;
            end
         end
         ST_RUN: begin
            if (!w_locked_s) begin
               w_state_next = ST_LOST;
            end
         end
         ST_LOST: begin
            w_state_next = ST_WAIT_LOCK;
         end
         default: begin
            w_state_next = ST_WAIT_LOCK;
         end
      endcase
   end

   assign w_run_active = (r_state == ST_RUN) && !w_pause;
   assign w_stay_run   = (r_state == ST_RUN) && (w_state_next == ST_RUN);

   // Dividers restart from zero on every RUN entry and freeze under pause.
   always_comb begin
      w_cpu_div_next = '0;
      w_ppu_div_next = '0;
      if (w_stay_run) begin
         if (w_pause) begin
            w_cpu_div_next = r_cpu_div;
            w_ppu_div_next = r_ppu_div;
         end else begin
            w_cpu_div_next = (r_cpu_div == c_cpu_last) ? '0 : r_cpu_div + c_cpu_one;
            w_ppu_div_next = (r_ppu_div == c_ppu_last) ? '0 : r_ppu_div + c_ppu_one;
         end
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_cpu_div <= '0;
         r_ppu_div <= '0;
      end else begin
         r_cpu_div <= w_cpu_div_next;
         r_ppu_div <= w_ppu_div_next;
      end
   end

   // Registered from next-state so release lands on the RUN-entry edge.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_run      <= 1'b0;
         r_lost_cnt <= '0;
      end else begin
         r_run <= (w_state_next == ST_RUN);
         if ((r_state == ST_RUN) && (w_state_next == ST_LOST) && (r_lost_cnt != 8'hFF)) begin
            r_lost_cnt <= r_lost_cnt + 8'd1;
         end
      end
   end

   assign sys_rst_n     = r_run;
   assign ready         = r_run;
   assign cpu_ce        = w_run_active && (r_cpu_div == c_cpu_last);
   assign ppu_ce        = w_run_active && (r_ppu_div == c_ppu_last);
   assign lock_lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nes_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_clock_sequencer
// Brief    : Self-checking bench for nes_clock_sequencer against a
//            lock-streak / strobe-phase reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_clock_sequencer;

   localparam int SYNC_STAGES = 2;
   localparam int LOCK_HOLD   = 16;
   localparam int CPU_DIV     = 12;
   localparam int PPU_DIV     = 4;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       pause = 1'b0;
   logic       sys_rst_n;
   logic       ready;
   logic       cpu_ce;
   logic       ppu_ce;
   logic [7:0] lock_lost_cnt;
   logic [11:0] obs;

   int vectors     = 0;
   int miscompares = 0;

   nes_clock_sequencer #(
      .SYNC_STAGES (SYNC_STAGES),
      .LOCK_HOLD   (LOCK_HOLD),
      .CPU_DIV     (CPU_DIV),
      .PPU_DIV     (PPU_DIV)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
`ifdef NES_CLOCK_SEQ_PAUSE_EN
      .pause         (pause),
`endif
      .pll_locked    (pll_locked),
      .sys_rst_n     (sys_rst_n),
      .ready         (ready),
      .cpu_ce        (cpu_ce),
      .ppu_ce        (ppu_ce),
      .lock_lost_cnt (lock_lost_cnt)
   );

   always #5 refclk = ~refclk;

   assign obs = {sys_rst_n, ready, cpu_ce, ppu_ce, lock_lost_cnt};

   // Reference model: released once locked_s (pll_locked delayed SYNC_STAGES
   // edges) has been seen high on LOCK_HOLD+1 consecutive edges; strobe phase
   // is the number of unpaused RUN cycles elapsed.
   bit m_sync_q[$];
   bit m_run;
   bit m_lost;
   int m_streak;
   int m_active;
   int m_losses;

   function automatic void model_reset();
      m_sync_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) m_sync_q.push_back(1'b0);
      m_run    = 1'b0;
      m_lost   = 1'b0;
      m_streak = 0;
      m_active = 0;
      m_losses = 0;
   endfunction

   function automatic void model_edge(input bit p, input bit ps);
      bit ls;
      ls = m_sync_q.pop_front();
      m_sync_q.push_back(p);
      if (m_run) begin
         if (!ls) begin
            m_run  = 1'b0;
            m_lost = 1'b1;
            if (m_losses < 255) m_losses++;
         end else if (!ps) begin
            m_active++;
         end
      end else if (m_lost) begin
         m_lost   = 1'b0;
         m_streak = 0;
      end else begin
         m_streak = ls ? m_streak + 1 : 0;
         if (m_streak == LOCK_HOLD + 1) begin
            m_run    = 1'b1;
            m_active = 0;
            m_streak = 0;
         end
      end
   endfunction

   function automatic logic [11:0] model_exp();
      logic en;
      en = m_run && !pause;
      return {m_run, m_run,
              en && ((m_active % CPU_DIV) == CPU_DIV - 1),
              en && ((m_active % PPU_DIV) == PPU_DIV - 1),
              8'(m_losses)};
   endfunction

   task automatic tick();
      @(posedge refclk);
      if (rst) model_edge(pll_locked, pause);
      else     model_reset();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      pll_locked = 1'b0;
      pause      = 1'b0;
      #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs, 12'h000);
         end
         tick();
      end
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL reset_wait cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
      end
   endtask

   task automatic test_hold_glitch();
      int first = 0;
      for (int i = 1; i <= 60; i++) begin
         pll_locked = (i <= 10) || (i >= 12);
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL glitch cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
         if (ready) begin
            first = i;
            break;
         end
      end
      vectors++;
      if (first != 12 + SYNC_STAGES + LOCK_HOLD) begin
         miscompares++;
         $display("FAIL glitch_release edge got=%0d exp=%0d", first, 12 + SYNC_STAGES + LOCK_HOLD);
      end
      vectors++;
      if (lock_lost_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL glitch_lostcnt got=%0d exp=0", lock_lost_cnt);
      end
   endtask

   task automatic test_power_up_release();
      int first  = 0;
      int early  = 0;
      pll_locked = 1'b1;
      rst        = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (obs !== 12'h000) begin
            miscompares++;
            $display("FAIL powerup_rst cyc=%0d got=%h exp=%h", i, obs, 12'h000);
         end
         tick();
      end
      rst = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL powerup cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         if (cpu_ce || ppu_ce) early++;
         tick();
         if (ready) begin
            first = i;
            break;
         end
      end
      vectors++;
      if (first != SYNC_STAGES + 1 + LOCK_HOLD) begin
         miscompares++;
         $display("FAIL powerup_release edge got=%0d exp=%0d", first, SYNC_STAGES + 1 + LOCK_HOLD);
      end
      vectors++;
      if (early != 0) begin
         miscompares++;
         $display("FAIL powerup_early_strobes got=%0d exp=0", early);
      end
   endtask

   task automatic test_strobe_cadence();
      logic [47:0] pm, cm, ep, ec;
      for (int c = 0; c < 48; c++) begin
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL cadence cyc=%0d got=%h exp=%h", c, obs, model_exp());
         end
         pm[c] = ppu_ce;
         cm[c] = cpu_ce;
         ep[c] = (c % 4) == 3;
         ec[c] = (c % 12) == 11;
         tick();
      end
      vectors++;
      if (pm !== ep) begin
         miscompares++;
         $display("FAIL cadence_ppu got=%h exp=%h", pm, ep);
      end
      vectors++;
      if (cm !== ec) begin
         miscompares++;
         $display("FAIL cadence_cpu got=%h exp=%h", cm, ec);
      end
      vectors++;
      if ((cm & ~pm) !== 48'h0) begin
         miscompares++;
         $display("FAIL cadence_align got=%h exp=0", cm & ~pm);
      end
   endtask

   task automatic test_lock_loss();
      int fall = 0;
      int rise = 0;
      for (int i = 1; i <= 60; i++) begin
         pll_locked = (i > 4);
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL lockloss cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
         if (!ready && fall == 0) fall = i;
         if (fall != 0 && ready) begin
            rise = i;
            break;
         end
      end
      vectors++;
      if (fall != SYNC_STAGES + 1) begin
         miscompares++;
         $display("FAIL lockloss_fall edge got=%0d exp=%0d", fall, SYNC_STAGES + 1);
      end
      vectors++;
      if (rise != 5 + SYNC_STAGES + LOCK_HOLD) begin
         miscompares++;
         $display("FAIL lockloss_relock edge got=%0d exp=%0d", rise, 5 + SYNC_STAGES + LOCK_HOLD);
      end
      vectors++;
      if (lock_lost_cnt !== 8'd1) begin
         miscompares++;
         $display("FAIL lockloss_cnt got=%0d exp=1", lock_lost_cnt);
      end
   endtask

`ifdef NES_CLOCK_SEQ_PAUSE_EN
   task automatic test_pause();
      int during = 0;
      int first_p = -1;
      int first_c = -1;
      for (int c = 0; c < 30; c++) begin
         pause = (c >= 5) && (c < 12);
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL pause cyc=%0d got=%h exp=%h", c, obs, model_exp());
         end
         if (pause && (cpu_ce || ppu_ce)) during++;
         if (c >= 12 && first_p < 0 && ppu_ce) first_p = c - 12;
         if (c >= 12 && first_c < 0 && cpu_ce) first_c = c - 12;
         tick();
      end
      pause = 1'b0;
      vectors++;
      if (during != 0) begin
         miscompares++;
         $display("FAIL pause_strobes got=%0d exp=0", during);
      end
      vectors++;
      if (first_p != 2) begin
         miscompares++;
         $display("FAIL pause_first_ppu got=%0d exp=2", first_p);
      end
      vectors++;
      if (first_c != 6) begin
         miscompares++;
         $display("FAIL pause_first_cpu got=%0d exp=6", first_c);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) pll_locked = ~pll_locked;
`ifdef NES_CLOCK_SEQ_PAUSE_EN
         pause = ($urandom_range(0, 99) < 15);
`endif
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
      end
      pause = 1'b0;
   endtask

   task automatic test_saturation_and_async_reset();
      int n;
      for (int k = 0; k < 260; k++) begin
         pll_locked = 1'b1;
         n = 0;
         while (!ready && n < 60) begin
            #1;
            vectors++;
            if (obs !== model_exp()) begin
               miscompares++;
               $display("FAIL sat_lock k=%0d got=%h exp=%h", k, obs, model_exp());
            end
            tick();
            n++;
         end
         pll_locked = 1'b0;
         n = 0;
         while (ready && n < 10) begin
            #1;
            vectors++;
            if (obs !== model_exp()) begin
               miscompares++;
               $display("FAIL sat_loss k=%0d got=%h exp=%h", k, obs, model_exp());
            end
            tick();
            n++;
         end
         if (ready) begin
            vectors++;
            miscompares++;
            $display("FAIL sat_timeout k=%0d got=ready exp=lost", k);
            break;
         end
      end
      vectors++;
      if (lock_lost_cnt !== 8'd255) begin
         miscompares++;
         $display("FAIL sat_cnt got=%0d exp=255", lock_lost_cnt);
      end
      pll_locked = 1'b1;
      for (int i = 0; i < 60; i++) begin
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL sat_relock cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
         if (ready && m_active >= 5) break;
      end
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL async_prerun got=%b exp=1", ready);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (obs !== 12'h000) begin
         miscompares++;
         $display("FAIL async_reset got=%h exp=%h", obs, 12'h000);
      end
      model_reset();
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         vectors++;
         if (obs !== model_exp()) begin
            miscompares++;
            $display("FAIL async_after cyc=%0d got=%h exp=%h", i, obs, model_exp());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_hold_glitch();
      test_power_up_release();
      test_strobe_cadence();
      test_lock_loss();
`ifdef NES_CLOCK_SEQ_PAUSE_EN
      test_pause();
`endif
      test_random();
      test_saturation_and_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
